// File: rtl/icap_feed_fifo.sv
// -----------------------------------------------------------------------------
// icap_feed_fifo
//
// Width-converting FIFO that accepts wide words (IN_W bits) and emits them as a
// sequence of narrow slices (OUT_W bits), for example to feed a configuration
// port that takes 32-bit words from a 128-bit DMA stream. The slice order is
// MSB-first or LSB-first. An optional per-byte bit reversal produces ICAP byte
// ordering.
//
// Parameters
//   IN_W      write-side word width; must equal RATIO*OUT_W with RATIO >= 2
//   OUT_W     read-side slice width; a multiple of 8 when BITSWAP = 1
//   DEPTH     number of IN_W entries; a power of two, >= 2
//   MSB_FIRST 1 = most significant slice emitted first, 0 = least significant
//   BITSWAP   1 = reverse the bit order inside every byte of each slice
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset; overrides every other input
//   flush      synchronous clear of contents and status; data_out is kept
//   write_en   write request for data_in (dropped when full)
//   data_in    wide write word
//   full       level == DEPTH (registered)
//   overflow   sticky: at least one write was dropped because the FIFO was full
//   read_en    request to emit one slice this cycle
//   data_out   registered output slice
//   data_valid data_out was loaded with a new slice on the last edge
//   empty      level == 0 (registered)
//   level      stored entries, including a partially emitted head entry
// -----------------------------------------------------------------------------
module icap_feed_fifo #(
    parameter int IN_W      = 128,
    parameter int OUT_W     = 32,
    parameter int DEPTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit BITSWAP   = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     write_en,
    input  logic [IN_W-1:0]          data_in,
    output logic                     full,
    output logic                     overflow,
    input  logic                     read_en,
    output logic [OUT_W-1:0]         data_out,
    output logic                     data_valid,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(RATIO);
    localparam int LW    = AW + 1;
    localparam int NBYTE = OUT_W / 8;

    logic [IN_W-1:0]  mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    slice_cnt;

    logic             write_ok;
    logic             emit;
    logic             last_slice;
    logic             pop;
    logic [LW-1:0]    level_next;
    logic [IN_W-1:0]  head_word;
    logic [CW-1:0]    slice_sel;
    logic [OUT_W-1:0] raw_slice;
    logic [OUT_W-1:0] emit_slice;

    // A write is refused whenever full is set, even if the head entry pops on
    // the same edge: the freed slot only becomes usable one cycle later.
    assign write_ok   = write_en && !full;
    assign emit       = read_en && !empty;
    assign last_slice = (slice_cnt == CW'(RATIO - 1));
    assign pop        = emit && last_slice;
    assign level_next = level + LW'(write_ok) - LW'(pop);

    assign head_word  = mem[rd_ptr];

    // MSB-first emission walks the slices from the top of the word downwards,
    // so slice k sits at physical position RATIO-1-k.
    assign slice_sel  = MSB_FIRST ? (CW'(RATIO - 1) - slice_cnt) : slice_cnt;
    assign raw_slice  = head_word[slice_sel*OUT_W +: OUT_W];

    // NOTE: every variable written in always_comb is assigned a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        emit_slice = raw_slice;
        if (BITSWAP) begin
            for (int b = 0; b < NBYTE; b++) begin
                for (int i = 0; i < 8; i++) begin
                    emit_slice[b*8 + i] = raw_slice[b*8 + 7 - i];
                end
            end
        end
    end

    // NOTE: the storage array has no reset. Stale contents are unreachable
    // because the pointers and level are cleared, and leaving the array out of
    // reset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            slice_cnt  <= '0;
            level      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            overflow   <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
        end else if (flush) begin
            // data_out is deliberately left alone so downstream sees a stable bus.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            slice_cnt  <= '0;
            level      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            overflow   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            if (write_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (write_en && full) begin
                overflow <= 1'b1;
            end

            data_valid <= emit;
            if (emit) begin
                data_out <= emit_slice;
                if (last_slice) begin
                    slice_cnt <= '0;
                    rd_ptr    <= rd_ptr + 1'b1;
                end else begin
                    slice_cnt <= slice_cnt + 1'b1;
                end
            end

            // Status flags are derived from the next level, so all three agree
            // in every cycle.
            level <= level_next;
            empty <= (level_next == '0);
            full  <= (level_next == LW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_icap_feed_fifo.sv
// -----------------------------------------------------------------------------
// tb_icap_feed_fifo
//
// Self-checking bench for icap_feed_fifo with IN_W=128, OUT_W=32, DEPTH=4.
// Three instances share the same stimulus:
//   dut_m  MSB_FIRST=1, BITSWAP=0 (main instance, checked throughout)
//   dut_l  MSB_FIRST=0
//   dut_b  BITSWAP=1
// A table of per-cycle vectors covers ordering, fill/overflow, drain, flush,
// full/pop collisions and back-to-back words. Short hand-written sequences
// cover paused reads, a flush in the middle of a word and a reset in the
// middle of a word.
// -----------------------------------------------------------------------------
module tb_icap_feed_fifo;

    logic         clk = 1'b0;
    logic         rst, flush, write_en, read_en;
    logic [127:0] data_in;

    logic         full_m, overflow_m, data_valid_m, empty_m;
    logic [31:0]  data_out_m;
    logic [2:0]   level_m;
    logic         full_l, overflow_l, data_valid_l, empty_l;
    logic [31:0]  data_out_l;
    logic [2:0]   level_l;
    logic         full_b, overflow_b, data_valid_b, empty_b;
    logic [31:0]  data_out_b;
    logic [2:0]   level_b;

    always #5 clk = ~clk;

    icap_feed_fifo #(.IN_W(128), .OUT_W(32), .DEPTH(4), .MSB_FIRST(1'b1), .BITSWAP(1'b0)) dut_m (
        .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .data_in(data_in),
        .full(full_m), .overflow(overflow_m), .read_en(read_en), .data_out(data_out_m),
        .data_valid(data_valid_m), .empty(empty_m), .level(level_m)
    );

    icap_feed_fifo #(.IN_W(128), .OUT_W(32), .DEPTH(4), .MSB_FIRST(1'b0), .BITSWAP(1'b0)) dut_l (
        .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .data_in(data_in),
        .full(full_l), .overflow(overflow_l), .read_en(read_en), .data_out(data_out_l),
        .data_valid(data_valid_l), .empty(empty_l), .level(level_l)
    );

    icap_feed_fifo #(.IN_W(128), .OUT_W(32), .DEPTH(4), .MSB_FIRST(1'b1), .BITSWAP(1'b1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .data_in(data_in),
        .full(full_b), .overflow(overflow_b), .read_en(read_en), .data_out(data_out_b),
        .data_valid(data_valid_b), .empty(empty_b), .level(level_b)
    );

    typedef struct {
        logic         flush;
        logic         we;
        logic [127:0] din;
        logic         re;
        logic         valid;
        logic [31:0]  dout;
        logic [2:0]   lvl;
        logic         ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [127:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] WB = 128'hAA995566_01020304_00000000_00000000;

    // Slice k of test word n (MSB-first numbering).
    function automatic logic [31:0] ws(int n, int k);
        return 32'hA000_0000 + 32'(n * 256 + k);
    endfunction

    function automatic logic [127:0] wd(int n);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w[127 - 32*k -: 32] = ws(n, k);
        return w;
    endfunction

    function automatic void add(logic fl, logic we, logic [127:0] din, logic re,
                                logic valid, logic [31:0] dout, int lvl, logic ovf);
        vec_t v;
        v.flush = fl; v.we = we; v.din = din; v.re = re;
        v.valid = valid; v.dout = dout; v.lvl = 3'(lvl); v.ovf = ovf;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic fl, logic we, logic [127:0] din, logic re);
        flush = fl; write_en = we; data_in = din; read_en = re;
    endtask

    task automatic check_status(string tag, logic valid, logic [31:0] dout, int lvl, logic ovf);
        check({tag, " valid"}, 128'(data_valid_m), 128'(valid));
        check({tag, " data"},  128'(data_out_m),   128'(dout));
        check({tag, " level"}, 128'(level_m),      128'(lvl));
        check({tag, " empty"}, 128'(empty_m),      128'(lvl == 0));
        check({tag, " full"},  128'(full_m),       128'(lvl == 4));
        check({tag, " ovf"},   128'(overflow_m),   128'(ovf));
    endtask

    initial begin
        logic [31:0] got[$];
        logic [31:0] exp8[8];
        int          pat[6];

        // ---------------- vector table ----------------
        // Single word, MSB-first order, then empty with data_out held.
        add(0, 1, W0, 1, 0, 32'h0,        1, 0);
        add(0, 0, '0, 1, 1, 32'h00112233, 1, 0);
        add(0, 0, '0, 1, 1, 32'h44556677, 1, 0);
        add(0, 0, '0, 1, 1, 32'h8899AABB, 1, 0);
        add(0, 0, '0, 1, 1, 32'hCCDDEEFF, 0, 0);
        add(0, 0, '0, 1, 0, 32'hCCDDEEFF, 0, 0);
        // Five writes with no reads: full after the 4th, overflow on the 5th.
        for (int n = 1; n <= 5; n++)
            add(0, 1, wd(n), 0, 0, 32'hCCDDEEFF, (n > 4) ? 4 : n, n == 5);
        // Drain: exactly 16 slices of words 1..4, word 5 never appears.
        for (int n = 1; n <= 4; n++)
            for (int k = 0; k < 4; k++)
                add(0, 0, '0, 1, 1, ws(n, k), (k == 3) ? 4 - n : 5 - n, 1);
        add(0, 0, '0, 1, 0, ws(4, 3), 0, 1);
        // Flush wins over a simultaneous write and read, clears overflow.
        add(1, 1, wd(6), 1, 0, ws(4, 3), 0, 0);
        // Full FIFO: write on the final-slice pop edge is dropped.
        for (int n = 1; n <= 4; n++) add(0, 1, wd(n), 0, 0, ws(4, 3), n, 0);
        for (int k = 0; k < 3; k++)  add(0, 0, '0, 1, 1, ws(1, k), 4, 0);
        add(0, 1, wd(7), 1, 1, ws(1, 3), 3, 1);
        add(1, 0, '0, 0, 0, ws(1, 3), 0, 0);
        // Level 2: write on the final-slice pop edge is accepted, level holds.
        add(0, 1, wd(1), 0, 0, ws(1, 3), 1, 0);
        add(0, 1, wd(2), 0, 0, ws(1, 3), 2, 0);
        for (int k = 0; k < 3; k++) add(0, 0, '0, 1, 1, ws(1, k), 2, 0);
        add(0, 1, wd(8), 1, 1, ws(1, 3), 2, 0);
        for (int k = 0; k < 4; k++) add(0, 0, '0, 1, 1, ws(2, k), (k == 3) ? 1 : 2, 0);
        for (int k = 0; k < 4; k++) add(0, 0, '0, 1, 1, ws(8, k), (k == 3) ? 0 : 1, 0);
        add(0, 0, '0, 1, 0, ws(8, 3), 0, 0);
        // Back-to-back: next word written on the final-slice edge, no gap.
        add(0, 1, wd(9), 1, 0, ws(8, 3), 1, 0);
        for (int k = 0; k < 3; k++) add(0, 0, '0, 1, 1, ws(9, k), 1, 0);
        add(0, 1, wd(10), 1, 1, ws(9, 3), 1, 0);
        for (int k = 0; k < 4; k++) add(0, 0, '0, 1, 1, ws(10, k), (k == 3) ? 0 : 1, 0);
        add(0, 0, '0, 1, 0, ws(10, 3), 0, 0);

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive(0, 1, W0, 1);
        cycle();
        cycle();
        check_status("reset", 0, 32'h0, 0, 0);
        rst = 1'b0;

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].we, vecs[i].din, vecs[i].re);
            cycle();
            check_status($sformatf("row%0d", i), vecs[i].valid, vecs[i].dout,
                         int'(vecs[i].lvl), vecs[i].ovf);
        end

        // ---------------- paused reads 1,1,0,0,1,1 ----------------
        drive(0, 1, wd(11), 0); cycle();
        drive(0, 1, wd(12), 0); cycle();
        drive(0, 0, '0, 0);
        pat = '{1, 1, 0, 0, 1, 1};
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            read_en = pat[c % 6] != 0;
            cycle();
            if (data_valid_m) got.push_back(data_out_m);
        end
        read_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp8[k]     = ws(11, k);
            exp8[k + 4] = ws(12, k);
        end
        check("pause count", 128'(got.size()), 128'(8));
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) check($sformatf("pause slice%0d", i), 128'(got[i]), 128'(exp8[i]));
            else                check($sformatf("pause slice%0d", i), 128'hX_DEAD, 128'(exp8[i]));
        end
        cycle();
        check_status("pause end", 0, ws(12, 3), 0, 0);

        // ---------------- flush mid-word ----------------
        drive(0, 1, wd(13), 0); cycle();
        drive(0, 1, wd(14), 0); cycle();
        drive(0, 0, '0, 1); cycle(); cycle();
        check("flushseq pre", 128'(data_out_m), 128'(ws(13, 1)));
        drive(1, 0, '0, 1); cycle();
        check_status("flushseq", 0, ws(13, 1), 0, 0);
        drive(0, 1, wd(15), 1); cycle();
        drive(0, 0, '0, 1); cycle();
        check_status("flushseq first", 1, ws(15, 0), 1, 0);
        repeat (4) cycle();
        check_status("flushseq end", 0, ws(15, 3), 0, 0);

        // ---------------- reset mid-word ----------------
        drive(0, 1, wd(16), 1); cycle();
        drive(0, 0, '0, 1); cycle(); cycle();
        rst = 1'b1;
        drive(0, 1, wd(17), 1); cycle();
        rst = 1'b0;
        check_status("rstseq", 0, 32'h0, 0, 0);
        drive(0, 1, wd(18), 1); cycle();
        drive(0, 0, '0, 1); cycle();
        check_status("rstseq first", 1, ws(18, 0), 1, 0);
        repeat (4) cycle();
        check_status("rstseq end", 0, ws(18, 3), 0, 0);

        // ---------------- LSB-first and bit-swap instances ----------------
        drive(0, 1, W0, 1); cycle();
        drive(0, 0, '0, 1);
        cycle(); check("lsb slice0", 128'(data_out_l), 128'(32'hCCDDEEFF));
        cycle(); check("lsb slice1", 128'(data_out_l), 128'(32'h8899AABB));
        cycle(); check("lsb slice2", 128'(data_out_l), 128'(32'h44556677));
        cycle(); check("lsb slice3", 128'(data_out_l), 128'(32'h00112233));
        check("lsb valid", 128'(data_valid_l), 128'(1));
        cycle(); check("lsb empty", 128'(empty_l), 128'(1));
        drive(0, 1, WB, 1); cycle();
        drive(0, 0, '0, 1);
        cycle();
        check("swap slice0", 128'(data_out_b), 128'(32'h5599AA66));
        check("noswap slice0", 128'(data_out_m), 128'(32'hAA995566));
        cycle();
        check("swap slice1", 128'(data_out_b), 128'(32'h8040C020));
        repeat (3) cycle();
        check("swap empty", 128'(empty_b), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icap_feed_fifo.md
ICAP_FEED_FIFO -- requirements
Module: icap_feed_fifo

Interface
REQ-001 SHALL have parameter IN_W, default 128, meaning write-side word width in bits.
REQ-002 SHALL have parameter OUT_W, default 32, meaning read-side slice width; IN_W SHALL equal RATIO*OUT_W with integer RATIO >= 2.
REQ-003 SHALL have parameter DEPTH, default 8, meaning number of IN_W entries; power of two, >= 2.
REQ-004 SHALL have parameter MSB_FIRST, default 1, meaning 1 = emit the most significant slice first, 0 = emit the least significant slice first.
REQ-005 SHALL have parameter BITSWAP, default 0, meaning 1 = reverse bit order within each byte of every emitted slice (ICAP byte order); OUT_W SHALL be a multiple of 8 when set.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 flush  in  1  synchronous clear of contents and status.
REQ-009 write_en  in  1  write request for data_in.
REQ-010 data_in  in  IN_W  wide write word.
REQ-011 full  out  1  level == DEPTH.
REQ-012 overflow  out  1  sticky flag: a write was dropped.
REQ-013 read_en  in  1  request to emit one slice this cycle.
REQ-014 data_out  out  OUT_W  registered output slice.
REQ-015 data_valid  out  1  data_out holds a newly emitted slice this cycle.
REQ-016 empty  out  1  level == 0.
REQ-017 level  out  $clog2(DEPTH)+1  number of stored entries, including a partially emitted entry.

Function
REQ-018 Write accepted on an edge with write_en=1 and full=0; the entry SHALL be stored at the write pointer and level incremented.
REQ-019 Write with full=1 SHALL be dropped and overflow set, even if a pop occurs on the same edge (no full-bypass).
REQ-020 Emit: on an edge with read_en=1 and empty=0, data_out SHALL load the slice selected by the slice counter and data_valid SHALL be 1 for the following cycle; otherwise data_valid SHALL be 0 and data_out SHALL hold its value.
REQ-021 The slice counter SHALL count 0..RATIO-1. An emit at count RATIO-1 SHALL pop the entry, advance the read pointer and wrap the counter to 0.
REQ-022 MSB_FIRST=1: slice k = data_in[IN_W-1-k*OUT_W -: OUT_W]. MSB_FIRST=0: slice k = data_in[k*OUT_W +: OUT_W].
REQ-023 BITSWAP SHALL be applied after slice selection. For example, byte 8'hAA maps to 8'h55.
REQ-024 Latency: the first slice of a word written into an empty FIFO SHALL appear (data_valid=1) after the second rising edge following the write edge, given read_en=1.
REQ-025 A write and a pop on the same edge SHALL leave level unchanged.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 A word written on the same edge as the final slice of the previous word SHALL be emitted back-to-back with no gap.
REQ-028 With read_en held at 1, emitted slices SHALL be contiguous, with no duplicates and no skips; de-asserting read_en SHALL pause emission without losing slice position.
REQ-029 flush SHALL clear level, both pointers, the slice counter, data_valid and overflow on the same edge. flush SHALL take priority over a write or read occurring in that cycle; data_out holds its value.
REQ-030 full, empty and level SHALL be registered and consistent with each other every cycle.

Reset
REQ-031 On an edge with rst=1, the block SHALL set level=0, empty=1, full=0, overflow=0, data_valid=0 and data_out=0, and zero the pointers and slice counter; rst SHALL have priority over flush, write and read.
REQ-032 Storage RAM contents need not be reset.
REQ-033 Reset asserted mid-word SHALL discard all remaining slices; the first word written after reset SHALL start at slice 0.

Verification (IN_W=128, OUT_W=32, DEPTH=4 unless noted)
REQ-034 Write 128'h00112233_44556677_8899AABB_CCDDEEFF with read_en=1 -> data_valid high for 4 consecutive cycles starting after the 2nd edge post-write, data_out = 00112233, 44556677, 8899AABB, CCDDEEFF; then empty=1. With MSB_FIRST=0 the order is reversed.
REQ-035 BITSWAP=1, write word with top slice 32'hAA995566 -> first data_out = 32'h5599AA66.
REQ-036 read_en=0, write 5 words -> full=1 after the 4th, level=4, overflow=1 after the 5th; then read_en=1 -> exactly 16 slices emitted, the 5th word never appears, overflow stays 1.
REQ-037 read_en pattern 1,1,0,0,1,1 across two words -> the slices emitted are exactly the 8 expected values in order, with no duplicates.
REQ-038 flush after 2 slices of a word with a second word queued -> next cycle data_valid=0, level=0, empty=1, overflow=0; the next written word emits from slice 0.
REQ-039 Simultaneous write and final-slice pop at level=4 (full=1) -> write dropped, overflow=1, level=3; at level=2 -> write accepted, level stays 2.
